rv_lfsr_source: RTL and testbench

// Synthesizable ready/valid transmitter: emits a programmable burst of

---
 rtl/rv_lfsr_source_if.sv | 24 ++
 rtl/rv_lfsr_source.sv | 137 +++++++++++++
 tb/tb_rv_lfsr_source.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_lfsr_source_if.sv
// rv_lfsr_source_if: ready/valid channel between the LFSR traffic source and a downstream sink.
//   m_valid  source -> sink  beat present
//   m_data   source -> sink  beat payload (DataWidth bits)
//   m_ready  sink -> source  sink accepts the beat this cycle
// Modports: master (the source side), slave (the sink side).
interface rv_lfsr_source_if #(
    parameter int unsigned DataWidth = 8
);
    logic                 m_valid;
    logic [DataWidth-1:0] m_data;
    logic                 m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/rv_lfsr_source.sv
// rv_lfsr_source: ready/valid traffic generator. It emits a programmable burst of
// pseudo-random beats and honours backpressure. Idle cycles can be inserted between
// beats at random.
// Ports:
//   clk         clock; all logic runs on the rising edge
//   rst         asynchronous reset, active-low
//   start       starts a burst; sampled only while idle
//   num_beats   burst length; sampled together with start
//   bubble_en   when set, randomly inserts idle cycles between beats
//   m           rv master channel (m_valid/m_data out, m_ready in)
//   busy        high while a burst is in progress
//   done        one-cycle pulse when a burst completes
//   beat_count  number of beats accepted in the current or last burst
module rv_lfsr_source #(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned CountWidth = 16,
    parameter logic [15:0] DataSeed   = 16'hACE1,
    parameter logic [15:0] BubbleSeed = 16'h1D2B
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CountWidth-1:0] num_beats,
    input  logic                  bubble_en,
    rv_lfsr_source_if.master      m,
    output logic                  busy,
    output logic                  done,
    output logic [CountWidth-1:0] beat_count
);

    localparam logic [15:0] Taps = 16'hB400;

    // One step of the 16-bit Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? Taps : 16'h0000);
    endfunction

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [DataWidth-1:0]  data_q, data_d;
    logic [15:0]           data_lfsr_q, data_lfsr_d;
    logic [15:0]           bubble_lfsr_q, bubble_lfsr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [CountWidth-1:0] num_q, num_d;
    logic                  done_q, done_d;

    logic                  hs;
    logic [15:0]           data_lfsr_next;
    logic [CountWidth-1:0] count_inc;
    logic                  valid_pick;

    assign hs             = valid_q & m.m_ready;
    assign data_lfsr_next = lfsr_step(data_lfsr_q);
    assign count_inc      = count_q + CountWidth'(1);
    // When a new valid is offered, bubble mode can leave a cycle empty.
    assign valid_pick     = bubble_en ? ~bubble_lfsr_q[0] : 1'b1;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        data_d        = data_q;
        data_lfsr_d   = data_lfsr_q;
        bubble_lfsr_d = bubble_lfsr_q;
        count_d       = count_q;
        num_d         = num_q;
        done_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = '0;
                    if (num_beats != '0) begin
                        state_d       = StRun;
                        num_d         = num_beats;
                        data_lfsr_d   = DataSeed;
                        bubble_lfsr_d = BubbleSeed;
                        // The first beat is always offered right away.
                        valid_d       = 1'b1;
                        data_d        = DataSeed[DataWidth-1:0];
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                bubble_lfsr_d = lfsr_step(bubble_lfsr_q);
                if (hs) begin
                    count_d     = count_inc;
                    data_lfsr_d = data_lfsr_next;
                    data_d      = data_lfsr_next[DataWidth-1:0];
                    if (count_inc == num_q) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        valid_d = valid_pick;
                    end
                end else if (!valid_q) begin
                    valid_d = valid_pick;
                end
                // A pending valid with no ready holds valid and data unchanged.
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            valid_q       <= 1'b0;
            data_q        <= '0;
            data_lfsr_q   <= DataSeed;
            bubble_lfsr_q <= BubbleSeed;
            count_q       <= '0;
            num_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            data_lfsr_q   <= data_lfsr_d;
            bubble_lfsr_q <= bubble_lfsr_d;
            count_q       <= count_d;
            num_q         <= num_d;
            done_q        <= done_d;
        end
    end

    assign m.m_valid  = valid_q;
    assign m.m_data   = data_q;
    assign busy       = (state_q == StRun);
    assign done       = done_q;
    assign beat_count = count_q;

endmodule

// File: tb/tb_rv_lfsr_source.sv
// tb_rv_lfsr_source: directed bench for rv_lfsr_source. It covers an 8-bit instance
// and a 16-bit instance that runs one full-period burst.
module tb_rv_lfsr_source;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_beats;
    logic        bubble_en;
    logic        busy;
    logic        done;
    logic [15:0] beat_count;

    logic        start16;
    logic [15:0] num_beats16;
    logic        busy16;
    logic        done16;
    logic [15:0] beat_count16;

    int vectors;
    int errs;

    rv_lfsr_source_if #(.DataWidth(8))  rv8 ();
    rv_lfsr_source_if #(.DataWidth(16)) rv16 ();

    rv_lfsr_source #(.DataWidth(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_beats  (num_beats),
        .bubble_en  (bubble_en),
        .m          (rv8.master),
        .busy       (busy),
        .done       (done),
        .beat_count (beat_count)
    );

    rv_lfsr_source #(.DataWidth(16)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .start      (start16),
        .num_beats  (num_beats16),
        .bubble_en  (1'b0),
        .m          (rv16.master),
        .busy       (busy16),
        .done       (done16),
        .beat_count (beat_count16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed low bytes of the data LFSR walk starting at 16'hACE1.
    logic [7:0]  exp8 [6];
    logic [31:0] rdy_pat;
    int          hs;
    int          dones;
    logic        pv;
    logic        rdy;
    logic [7:0]  pd;
    logic        seen;
    logic        gap;
    logic        rep;

    initial begin
        exp8[0] = 8'hE1; exp8[1] = 8'h70; exp8[2] = 8'h38;
        exp8[3] = 8'h9C; exp8[4] = 8'h4E; exp8[5] = 8'h27;
        rdy_pat = 32'hA5A5_3C96;
        vectors = 0;
        errs = 0;
        rst = 1'b0;
        start = 1'b0; num_beats = 16'd0; bubble_en = 1'b0; rv8.m_ready = 1'b0;
        start16 = 1'b0; num_beats16 = 16'd0; rv16.m_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_valid", {31'd0, rv8.m_valid}, 32'd0);
        check("rst_data", {24'd0, rv8.m_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {16'd0, beat_count}, 32'd0);
        rst = 1'b1;
        tick();

        // Four beats, no bubbles, sink always ready
        start = 1'b1; num_beats = 16'd4; rv8.m_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_valid%0d", i), {31'd0, rv8.m_valid}, 32'd1);
            check($sformatf("t2_data%0d", i), {24'd0, rv8.m_data}, {24'd0, exp8[i]});
            check($sformatf("t2_busy%0d", i), {31'd0, busy}, 32'd1);
            check($sformatf("t2_done%0d", i), {31'd0, done}, 32'd0);
            tick();
        end
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_valid_end", {31'd0, rv8.m_valid}, 32'd0);
        check("t2_busy_end", {31'd0, busy}, 32'd0);
        check("t2_count", {16'd0, beat_count}, 32'd4);
        tick();
        check("t2_done_pulse", {31'd0, done}, 32'd0);
        check("t2_count_hold", {16'd0, beat_count}, 32'd4);

        // Three beats under an irregular ready pattern
        rv8.m_ready = 1'b0;
        start = 1'b1; num_beats = 16'd3;
        tick();
        start = 1'b0;
        hs = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            rdy = rdy_pat[c % 32];
            rv8.m_ready = rdy;
            pv = rv8.m_valid;
            pd = rv8.m_data;
            tick();
            if (pv && rdy) begin
                check($sformatf("t3_data%0d", hs), {24'd0, pd}, {24'd0, exp8[hs % 6]});
                hs++;
            end else if (pv && !rdy) begin
                check("t3_hold_valid", {31'd0, rv8.m_valid}, 32'd1);
                check("t3_hold_data", {24'd0, rv8.m_data}, {24'd0, pd});
            end
            if (done) seen = 1'b1;
        end
        check("t3_done_seen", {31'd0, seen}, 32'd1);
        check("t3_handshakes", hs, 32'd3);
        check("t3_count", {16'd0, beat_count}, 32'd3);

        // Zero-length burst
        rv8.m_ready = 1'b1;
        start = 1'b1; num_beats = 16'd0;
        tick();
        start = 1'b0;
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_valid", {31'd0, rv8.m_valid}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_count", {16'd0, beat_count}, 32'd0);
        tick();
        check("t4_done_pulse", {31'd0, done}, 32'd0);
        check("t4_valid_later", {31'd0, rv8.m_valid}, 32'd0);

        // Reset taken mid-burst while a beat is stalled
        rv8.m_ready = 1'b0;
        start = 1'b1; num_beats = 16'd5;
        tick();
        start = 1'b0;
        tick();
        check("t1_pending_valid", {31'd0, rv8.m_valid}, 32'd1);
        rst = 1'b0;
        tick();
        check("t1_valid", {31'd0, rv8.m_valid}, 32'd0);
        check("t1_data", {24'd0, rv8.m_data}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_count", {16'd0, beat_count}, 32'd0);
        rst = 1'b1;
        tick();
        rv8.m_ready = 1'b1;
        start = 1'b1; num_beats = 16'd1;
        tick();
        start = 1'b0;
        check("t1_first_data", {24'd0, rv8.m_data}, 32'hE1);
        check("t1_first_valid", {31'd0, rv8.m_valid}, 32'd1);
        tick();
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_count_end", {16'd0, beat_count}, 32'd1);

        // Bubbles enabled, start and num_beats disturbed mid-burst
        bubble_en = 1'b1;
        start = 1'b1; num_beats = 16'd6;
        tick();
        num_beats = 16'd2;
        hs = 0; seen = 1'b0; gap = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            if (c >= 2) start = 1'b0;
            pv = rv8.m_valid;
            pd = rv8.m_data;
            if (pv && !busy) check("t5_valid_outside_burst", 32'd1, 32'd0);
            if (!pv && busy && hs > 0) gap = 1'b1;
            tick();
            if (pv) begin
                check($sformatf("t5_data%0d", hs), {24'd0, pd}, {24'd0, exp8[hs % 6]});
                hs++;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        bubble_en = 1'b0;
        check("t5_done_seen", {31'd0, seen}, 32'd1);
        check("t5_handshakes", hs, 32'd6);
        check("t5_count", {16'd0, beat_count}, 32'd6);
        check("t5_gap_seen", {31'd0, gap}, 32'd1);
        tick();
        check("t5_idle_after", {31'd0, busy}, 32'd0);

        // Full-period burst on the 16-bit instance
        rv16.m_ready = 1'b1;
        start16 = 1'b1; num_beats16 = 16'hFFFF;
        tick();
        start16 = 1'b0;
        check("t6_first_data", {16'd0, rv16.m_data}, 32'hACE1);
        hs = 0; dones = 0; rep = 1'b0; seen = 1'b0;
        for (int c = 0; c < 65600 && !seen; c++) begin
            if (rv16.m_valid) begin
                if (hs > 0 && rv16.m_data == 16'hACE1) rep = 1'b1;
                hs++;
            end
            tick();
            if (done16) begin
                dones++;
                seen = 1'b1;
            end
        end
        tick(); tick();
        if (done16) dones++;
        check("t6_done_seen", {31'd0, seen}, 32'd1);
        check("t6_beats", hs, 32'd65535);
        check("t6_no_repeat", {31'd0, rep}, 32'd0);
        check("t6_done_once", dones, 32'd1);
        check("t6_count", {16'd0, beat_count16}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
